board_write_ctl: RTL and testbench

//  Sequencer/arbiter owning the write port of one board_mem instance (12x12 grid, 2-bit cells).

---
 rtl/board_write_ctl.sv | 208 ++++++++++++++++++++
 tb/tb_board_write_ctl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_write_ctl.sv
// Write-port sequencer for one board_mem: clear sweep, shot writes and ship placement share the port.
// Latency: request sampled at edge N, write/ack registered at edge N+1; clear writes one cell per cycle.
// Backpressure: requests are held until ack/err; ignored while the clear sweep runs; at most one grant per 2 cycles.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   clear_start            -> busy (high for the 144 clear-write cycles)
//   shot_req/x/y/hit       -> shot_ack
//   place_req/x/y          -> place_ack / place_err
//   write_addr {y,x}, write_data (00 EMPTY, 01 SHIP, 10 MISS, 11 HIT), write_enable -> board_mem
// Optional: define BOARD_WRITE_CTL_RR_EN for round-robin shot/place arbitration
// (default: fixed priority, shot over place). Clear always has absolute priority.
module board_write_ctl #(
    parameter int X_SIZE       = 12,
    parameter int Y_SIZE       = 12,
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear_start,
    output logic                                 busy,
    input  logic                                 shot_req,
    input  logic [X_ADDR_WIDTH-1:0]              shot_x,
    input  logic [Y_ADDR_WIDTH-1:0]              shot_y,
    input  logic                                 shot_hit,
    output logic                                 shot_ack,
    input  logic                                 place_req,
    input  logic [X_ADDR_WIDTH-1:0]              place_x,
    input  logic [Y_ADDR_WIDTH-1:0]              place_y,
    output logic                                 place_ack,
    output logic                                 place_err,
    output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] write_addr,
    output logic [1:0]                           write_data,
    output logic                                 write_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [X_ADDR_WIDTH-1:0] cnt_x;
    logic [Y_ADDR_WIDTH-1:0] cnt_y;
    logic                    cnt_last;

    // Request captured at the IDLE edge and replayed in the GRANT cycle
    logic                    src_shot;
    logic [X_ADDR_WIDTH-1:0] cap_x;
    logic [Y_ADDR_WIDTH-1:0] cap_y;
    logic                    cap_hit;
    logic                    cap_in_range;

    logic                    pick_shot;

    // Next values of the registered outputs
    logic                                 busy_nxt;
    logic                                 we_nxt;
    logic                                 shot_ack_nxt;
    logic                                 place_ack_nxt;
    logic                                 place_err_nxt;
    logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] addr_nxt;
    logic [1:0]                           data_nxt;

    assign cnt_last = (cnt_x == X_ADDR_WIDTH'(X_SIZE - 1)) &&
                      (cnt_y == Y_ADDR_WIDTH'(Y_SIZE - 1));

    assign cap_in_range = (int'(cap_x) < X_SIZE) && (int'(cap_y) < Y_SIZE);

`ifdef BOARD_WRITE_CTL_RR_EN
    // Set when shot was granted last, so place wins the next tie
    logic prefer_place;
    assign pick_shot = shot_req && (!place_req || !prefer_place);
`else
    assign pick_shot = shot_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (clear_start)                state_nxt = CLEAR;
                else if (shot_req || place_req) state_nxt = GRANT;
                else                            state_nxt = IDLE;
            end
            CLEAR: begin
                if (clear_start)   state_nxt = CLEAR;
                else if (cnt_last) state_nxt = IDLE;
                else               state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep counter and request capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_x    <= '0;
            cnt_y    <= '0;
            src_shot <= 1'b0;
            cap_x    <= '0;
            cap_y    <= '0;
            cap_hit  <= 1'b0;
`ifdef BOARD_WRITE_CTL_RR_EN
            prefer_place <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        cnt_x <= '0;
                        cnt_y <= '0;
                    end else if (shot_req || place_req) begin
                        src_shot <= pick_shot;
                        cap_x    <= pick_shot ? shot_x : place_x;
                        cap_y    <= pick_shot ? shot_y : place_y;
                        cap_hit  <= shot_hit;
`ifdef BOARD_WRITE_CTL_RR_EN
                        prefer_place <= pick_shot;
`endif
                    end
                end
                CLEAR: begin
                    if (clear_start) begin
                        cnt_x <= '0;
                        cnt_y <= '0;
                    end else if (cnt_x == X_ADDR_WIDTH'(X_SIZE - 1)) begin
                        cnt_x <= '0;
                        cnt_y <= cnt_y + 1'b1;
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: computes what the output registers load at the next edge
    always_comb begin
        busy_nxt      = 1'b0;
        we_nxt        = 1'b0;
        shot_ack_nxt  = 1'b0;
        place_ack_nxt = 1'b0;
        place_err_nxt = 1'b0;
        addr_nxt      = write_addr;
        data_nxt      = write_data;
        case (state)
            CLEAR: begin
                busy_nxt = 1'b1;
                we_nxt   = 1'b1;
                addr_nxt = {cnt_y, cnt_x};
                data_nxt = 2'b00;
            end
            GRANT: begin
                if (src_shot) begin
                    we_nxt       = 1'b1;
                    addr_nxt     = {cap_y, cap_x};
                    data_nxt     = {1'b1, cap_hit};
                    shot_ack_nxt = 1'b1;
                end else if (cap_in_range) begin
                    we_nxt        = 1'b1;
                    addr_nxt      = {cap_y, cap_x};
                    data_nxt      = 2'b01;
                    place_ack_nxt = 1'b1;
                end else begin
                    place_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy         <= 1'b0;
            write_enable <= 1'b0;
            shot_ack     <= 1'b0;
            place_ack    <= 1'b0;
            place_err    <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            busy         <= busy_nxt;
            write_enable <= we_nxt;
            shot_ack     <= shot_ack_nxt;
            place_ack    <= place_ack_nxt;
            place_err    <= place_err_nxt;
            write_addr   <= addr_nxt;
            write_data   <= data_nxt;
        end
    end

endmodule

// File: tb/tb_board_write_ctl.sv
// Bench for board_write_ctl: randomized requests against a transaction-level board model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters hold req until ack/err, then drop it.
module tb_board_write_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_start;
    logic       busy;
    logic       shot_req;
    logic [3:0] shot_x;
    logic [3:0] shot_y;
    logic       shot_hit;
    logic       shot_ack;
    logic       place_req;
    logic [3:0] place_x;
    logic [3:0] place_y;
    logic       place_ack;
    logic       place_err;
    logic [7:0] write_addr;
    logic [1:0] write_data;
    logic       write_enable;

    int checks   = 0;
    int failures = 0;

    // Board contents as seen through the DUT's write strobes, and as the model expects
    logic [1:0] dut_mem [256];
    logic [1:0] ref_mem [256];
    logic [7:0] last_addr;
    logic [1:0] last_data;
    bit         last_shot;   // last granted source was shot
    bit         rr;

    board_write_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .clear_start  (clear_start),
        .busy         (busy),
        .shot_req     (shot_req),
        .shot_x       (shot_x),
        .shot_y       (shot_y),
        .shot_hit     (shot_hit),
        .shot_ack     (shot_ack),
        .place_req    (place_req),
        .place_x      (place_x),
        .place_y      (place_y),
        .place_ack    (place_ack),
        .place_err    (place_err),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] mk(bit b, bit we, bit sa, bit pa, bit pe,
                                       logic [7:0] a, logic [1:0] d);
        return {b, we, sa, pa, pe, a, d};
    endfunction

    function automatic logic [14:0] obs();
        return {busy, write_enable, shot_ack, place_ack, place_err, write_addr, write_data};
    endfunction

    function automatic logic [14:0] quiet();
        return mk(0, 0, 0, 0, 0, last_addr, last_data);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (write_enable === 1'b1) dut_mem[write_addr] = write_data;
    endtask

    // Expected outcome of one granted request, applying the board rules
    task automatic model_serve(input bit is_shot, input logic [3:0] x, input logic [3:0] y,
                               input bit hit, output logic [14:0] e);
        logic [7:0] a;
        logic [1:0] d;
        a = {y, x};
        if (is_shot) begin
            d = hit ? 2'b11 : 2'b10;
            ref_mem[a] = d; last_addr = a; last_data = d;
            e = mk(0, 1, 1, 0, 0, a, d);
        end else if (int'(x) < 12 && int'(y) < 12) begin
            d = 2'b01;
            ref_mem[a] = d; last_addr = a; last_data = d;
            e = mk(0, 1, 0, 1, 0, a, d);
        end else begin
            e = mk(0, 0, 0, 0, 1, last_addr, last_data);
        end
        last_shot = is_shot;
    endtask

    task automatic drive_shot(input bit req, input logic [3:0] x, input logic [3:0] y, input bit hit);
        shot_req = req; shot_x = x; shot_y = y; shot_hit = hit;
    endtask

    task automatic drive_place(input bit req, input logic [3:0] x, input logic [3:0] y);
        place_req = req; place_x = x; place_y = y;
    endtask

    // One requester, held for n consecutive serves
    task automatic run_single(input bit is_shot, input logic [3:0] x, input logic [3:0] y,
                              input bit hit, input int n);
        logic [14:0] e;
        if (is_shot) drive_shot(1, x, y, hit);
        else         drive_place(1, x, y);
        for (int s = 0; s < n; s++) begin
            tick(); check_val("single_gap", 32'(obs()), 32'(quiet()));
            tick(); model_serve(is_shot, x, y, hit, e);
            check_val(is_shot ? "shot_serve" : "place_serve", 32'(obs()), 32'(e));
        end
        shot_req = 0; place_req = 0;
        tick(); check_val("single_after", 32'(obs()), 32'(quiet()));
    endtask

    // Shot and place raised on the same edge
    task automatic run_pair(input logic [3:0] sx, input logic [3:0] sy, input bit hit,
                            input logic [3:0] px, input logic [3:0] py);
        logic [14:0] e;
        bit          shot_first;
        shot_first = !(rr && last_shot);
        drive_shot(1, sx, sy, hit);
        drive_place(1, px, py);
        tick(); check_val("pair_gap0", 32'(obs()), 32'(quiet()));
        tick(); model_serve(shot_first, shot_first ? sx : px, shot_first ? sy : py, hit, e);
        check_val("pair_first", 32'(obs()), 32'(e));
        if (shot_first) shot_req = 0; else place_req = 0;
        tick(); check_val("pair_gap1", 32'(obs()), 32'(quiet()));
        tick(); model_serve(!shot_first, shot_first ? px : sx, shot_first ? py : sy, hit, e);
        check_val("pair_second", 32'(obs()), 32'(e));
        shot_req = 0; place_req = 0;
        tick(); check_val("pair_after", 32'(obs()), 32'(quiet()));
    endtask

    // Clear sweep; optional restart, reset or shot raised at a given observed tick (-1 = off)
    task automatic clear_sweep(input int restart_at, input int rst_at, input int shot_at,
                               input logic [3:0] sx, input logic [3:0] sy, input bit hit);
        logic [14:0] e;
        logic [7:0]  a;
        int          idx;
        int          m;
        bit          rflag;
        bit          done;
        bit          was_reset;
        clear_start = 1;
        tick(); check_val("clr_start", 32'(obs()), 32'(quiet()));
        clear_start = 0;
        idx = 0; m = 0; rflag = 0; done = 0; was_reset = 0;
        while (!done && m < 400) begin
            tick(); m++;
            a = {4'(idx / 12), 4'(idx % 12)};
            check_val("clr_write", 32'(obs()), 32'(mk(1, 1, 0, 0, 0, a, 2'b00)));
            ref_mem[a] = 2'b00; last_addr = a; last_data = 2'b00;
            if (m == rst_at) begin
                rst = 0;
                tick();
                check_val("rst_mid_sweep", 32'(obs()), 32'(0));
                last_addr = 0; last_data = 0; last_shot = 0;
                rst = 1;
                was_reset = 1;
                done = 1;
            end else begin
                if (idx == 143 && !rflag) done = 1;
                else idx = rflag ? 0 : idx + 1;
                rflag = 0;
                if (m == restart_at) begin
                    clear_start = 1; rflag = 1;
                end else begin
                    clear_start = 0;
                end
                if (m == shot_at) drive_shot(1, sx, sy, hit);
            end
        end
        clear_start = 0;
        if (m >= 400) check_val("clr_bound", 32'(m), 32'(0));
        tick(); check_val("clr_end", 32'(obs()), 32'(quiet()));
        if (!was_reset && shot_at > 0) begin
            tick(); model_serve(1, sx, sy, hit, e);
            check_val("shot_after_clr", 32'(obs()), 32'(e));
            shot_req = 0;
            tick(); check_val("shot_after_clr_q", 32'(obs()), 32'(quiet()));
        end
    endtask

    initial begin
        logic [3:0] x, y, px, py;
        int         diff;
`ifdef BOARD_WRITE_CTL_RR_EN
        rr = 1;
`else
        rr = 0;
`endif
        for (int i = 0; i < 256; i++) begin
            dut_mem[i] = 2'b00; ref_mem[i] = 2'b00;
        end
        last_addr = 0; last_data = 0; last_shot = 0;
        rst = 0; clear_start = 0;
        drive_shot(0, 0, 0, 0);
        drive_place(0, 0, 0);
        tick(); tick();
        check_val("reset_outputs", 32'(obs()), 32'(0));
        rst = 1;
        tick(); check_val("idle_after_reset", 32'(obs()), 32'(0));

        // Full sweep
        clear_sweep(-1, -1, -1, 0, 0, 0);
        // Placement in range, then out of range
        run_single(0, 4'd3, 4'd5, 0, 1);
        run_single(0, 4'd12, 4'd0, 0, 1);
        // Simultaneous shot/place; then again right after a shot grant
        run_pair(4'd0, 4'd11, 1, 4'd1, 4'd1);
        run_single(1, 4'd7, 4'd2, 0, 1);
        run_pair(4'd0, 4'd11, 1, 4'd1, 4'd1);
        // Shot raised mid-sweep waits for the sweep to end
        clear_sweep(-1, -1, 30, 4'd4, 4'd9, 0);
        // Sweep restarted mid-way
        clear_sweep(40, -1, -1, 0, 0, 0);

        for (int it = 0; it < 40; it++) begin
            x  = 4'($urandom_range(0, 11));
            y  = 4'($urandom_range(0, 11));
            px = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
            py = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
            case ($urandom_range(0, 3))
                0: run_single(1, x, y, 1'($urandom_range(0, 1)), 1);
                1: run_single(0, px, py, 0, 1);
                2: run_pair(x, y, 1'($urandom_range(0, 1)), px, py);
                default: run_single(1'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 1)),
                                    $urandom_range(2, 3));
            endcase
        end

        // Reset while cell 50 is being written, then a fresh sweep
        clear_sweep(-1, 51, -1, 0, 0, 0);
        clear_sweep(-1, -1, -1, 0, 0, 0);
        run_single(1, 4'd11, 4'd11, 1, 1);

        diff = 0;
        for (int i = 0; i < 256; i++) if (dut_mem[i] !== ref_mem[i]) diff++;
        check_val("board_contents", 32'(diff), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
